// File: rtl/rsdec_pkg.sv
// Shared definitions for the RS(255,239) syndrome stage: field constants,
// alpha-power table and a GF(2^8) multiply helper.
package rsdec_pkg;

  localparam logic [8:0] GF_POLY = 9'h11D;
  localparam int         SYM_W   = 8;
  localparam int         NSYN    = 16;
  localparam int         N       = 255;
  localparam int         FCR     = 0;

  // alpha^0 .. alpha^16 over 0x11D
  localparam logic [SYM_W-1:0] ALPHA_POW [17] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
    8'h1D, 8'h3A, 8'h74, 8'hE8, 8'hCD, 8'h87, 8'h13, 8'h26, 8'h4C
  };

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

  // Shift-and-add multiply; with a constant b it folds to an XOR network.
  function automatic logic [SYM_W-1:0] gf_mul(input logic [SYM_W-1:0] a,
                                              input logic [SYM_W-1:0] b);
    logic [SYM_W-1:0] p;
    logic [SYM_W-1:0] x;
    p = '0;
    x = a;
    for (int k = 0; k < SYM_W; k++) begin
      if (b[k]) p = p ^ x;
      x = x[SYM_W-1] ? ((x << 1) ^ GF_POLY[SYM_W-1:0]) : (x << 1);
    end
    return p;
  endfunction

endpackage

// File: rtl/rsdec_syn_cell.sv
// One syndrome accumulator: Horner step acc*alpha^EXP ^ din.
// acc_next exposes the value the register takes this edge so the top can
// latch a completed syndrome without an extra cycle.
module rsdec_syn_cell
  import rsdec_pkg::*;
#(
  parameter int EXP = 0
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             load,
  input  logic             step,
  input  logic [SYM_W-1:0] din,
  output logic [SYM_W-1:0] acc_next
);

  localparam logic [SYM_W-1:0] ROOT = ALPHA_POW[EXP];

  logic [SYM_W-1:0] acc;

  always_comb begin
    acc_next = acc;
    if (load)      acc_next = din;
    else if (step) acc_next = gf_mul(acc, ROOT) ^ din;
  end

  always_ff @(posedge clk) begin
    if (!clrn) acc <= '0;
    else       acc <= acc_next;
  end

endmodule

// File: rtl/rsdec_syn.sv
// RS(255,239) syndrome calculator: 16 Horner accumulators, symbol counter,
// IDLE/ACC control and the latched syndrome set handed to Berlekamp.
module rsdec_syn
  import rsdec_pkg::*;
(
  input  logic             clk,
  input  logic             clrn,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [SYM_W-1:0] din,
  output logic [SYM_W-1:0] syndrome0,
  output logic [SYM_W-1:0] syndrome1,
  output logic [SYM_W-1:0] syndrome2,
  output logic [SYM_W-1:0] syndrome3,
  output logic [SYM_W-1:0] syndrome4,
  output logic [SYM_W-1:0] syndrome5,
  output logic [SYM_W-1:0] syndrome6,
  output logic [SYM_W-1:0] syndrome7,
  output logic [SYM_W-1:0] syndrome8,
  output logic [SYM_W-1:0] syndrome9,
  output logic [SYM_W-1:0] syndrome10,
  output logic [SYM_W-1:0] syndrome11,
  output logic [SYM_W-1:0] syndrome12,
  output logic [SYM_W-1:0] syndrome13,
  output logic [SYM_W-1:0] syndrome14,
  output logic [SYM_W-1:0] syndrome15,
  output logic             syn_valid,
  output logic             err_flag,
  output logic             busy
);

  // Input contract: no backpressure. A symbol is consumed on every edge where
  // in_valid=1; in_sof with in_valid starts (or restarts) a codeword, and
  // syn_valid is a one-cycle pulse with no acknowledge.
  localparam logic [7:0] N_LAST = 8'(N - 1);

  state_t           state, state_next;
  logic [7:0]       count, count_next;
  logic             load, step, done;
  logic             any_nz;
  logic [SYM_W-1:0] acc_next [NSYN];
  logic [SYM_W-1:0] syn_q    [NSYN];

  for (genvar i = 0; i < NSYN; i++) begin : g_cell
    rsdec_syn_cell #(.EXP(FCR + i)) u_cell (
      .clk      (clk),
      .clrn     (clrn),
      .load     (load),
      .step     (step),
      .din      (din),
      .acc_next (acc_next[i])
    );
  end

  always_comb begin
    state_next = state;
    count_next = count;
    load       = 1'b0;
    step       = 1'b0;
    done       = 1'b0;
    if (in_valid) begin
      if (in_sof) begin
        load       = 1'b1;
        count_next = 8'd1;
        state_next = ST_ACC;
      end else if (state == ST_ACC) begin
        step = 1'b1;
        if (count == N_LAST) begin
          done       = 1'b1;
          count_next = 8'd0;
          state_next = ST_IDLE;
        end else begin
          count_next = count + 8'd1;
        end
      end
    end
  end

  always_comb begin
    any_nz = 1'b0;
    for (int i = 0; i < NSYN; i++) any_nz = any_nz | (|acc_next[i]);
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state     <= ST_IDLE;
      count     <= '0;
      syn_valid <= 1'b0;
      err_flag  <= 1'b0;
      for (int i = 0; i < NSYN; i++) syn_q[i] <= '0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      syn_valid <= done;
      if (done) begin
        err_flag <= any_nz;
        for (int i = 0; i < NSYN; i++) syn_q[i] <= acc_next[i];
      end
    end
  end

  assign busy       = (state == ST_ACC);
  assign syndrome0  = syn_q[0];
  assign syndrome1  = syn_q[1];
  assign syndrome2  = syn_q[2];
  assign syndrome3  = syn_q[3];
  assign syndrome4  = syn_q[4];
  assign syndrome5  = syn_q[5];
  assign syndrome6  = syn_q[6];
  assign syndrome7  = syn_q[7];
  assign syndrome8  = syn_q[8];
  assign syndrome9  = syn_q[9];
  assign syndrome10 = syn_q[10];
  assign syndrome11 = syn_q[11];
  assign syndrome12 = syn_q[12];
  assign syndrome13 = syn_q[13];
  assign syndrome14 = syn_q[14];
  assign syndrome15 = syn_q[15];

endmodule

// File: tb/tb_rsdec_syn.sv
// Randomized bench for rsdec_syn: syndromes from direct polynomial evaluation
// r(alpha^(FCR+i)) are queued per codeword and compared by a monitor.
module tb_rsdec_syn;

  localparam int FCR_M = 0;

  logic       clk = 1'b0;
  logic       clrn;
  logic       in_valid;
  logic       in_sof;
  logic [7:0] din;
  logic [7:0] syndrome0, syndrome1, syndrome2, syndrome3;
  logic [7:0] syndrome4, syndrome5, syndrome6, syndrome7;
  logic [7:0] syndrome8, syndrome9, syndrome10, syndrome11;
  logic [7:0] syndrome12, syndrome13, syndrome14, syndrome15;
  logic       syn_valid;
  logic       err_flag;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [128:0] exp_q [$];
  int           due_q [$];
  logic [128:0] last;
  logic [128:0] obs;
  bit           hold_en;
  logic [7:0]   cw [255];
  logic [7:0]   exp_t [255];

  rsdec_syn dut (
    .clk(clk), .clrn(clrn), .in_valid(in_valid), .in_sof(in_sof), .din(din),
    .syndrome0(syndrome0), .syndrome1(syndrome1), .syndrome2(syndrome2),
    .syndrome3(syndrome3), .syndrome4(syndrome4), .syndrome5(syndrome5),
    .syndrome6(syndrome6), .syndrome7(syndrome7), .syndrome8(syndrome8),
    .syndrome9(syndrome9), .syndrome10(syndrome10), .syndrome11(syndrome11),
    .syndrome12(syndrome12), .syndrome13(syndrome13), .syndrome14(syndrome14),
    .syndrome15(syndrome15), .syn_valid(syn_valid), .err_flag(err_flag),
    .busy(busy)
  );

  assign obs = {err_flag, syndrome15, syndrome14, syndrome13, syndrome12,
                syndrome11, syndrome10, syndrome9, syndrome8, syndrome7,
                syndrome6, syndrome5, syndrome4, syndrome3, syndrome2,
                syndrome1, syndrome0};

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // reference field arithmetic
  function automatic logic [7:0] fmul(input logic [7:0] a, input logic [7:0] b);
    int acc, aa, bb;
    acc = 0; aa = a; bb = b;
    while (bb != 0) begin
      if (bb % 2 == 1) acc = acc ^ aa;
      aa = aa * 2;
      if (aa >= 256) aa = aa ^ 'h11D;
      bb = bb / 2;
    end
    return 8'(acc);
  endfunction

  // r(x) = sum cw[j] * x^(254-j), evaluated at alpha^(FCR+i)
  function automatic logic [128:0] model();
    logic [128:0] e;
    logic [7:0]   s;
    e = '0;
    for (int i = 0; i < 16; i++) begin
      s = 8'h00;
      for (int j = 0; j < 255; j++)
        s = s ^ fmul(cw[j], exp_t[((FCR_M + i) * (254 - j)) % 255]);
      e[8*i +: 8] = s;
      if (s != 8'h00) e[128] = 1'b1;
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [128:0] got,
                       input logic [128:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: n symbols of cw, sof on the first, optional random stalls
  task automatic send_cw(input int n, input int max_stall);
    int stall;
    for (int j = 0; j < n; j++) begin
      stall = 0;
      if (max_stall > 0 && $urandom_range(0, 3) == 0)
        stall = $urandom_range(1, max_stall);
      repeat (stall) begin
        in_valid = 1'b0;
        in_sof   = 1'($urandom_range(0, 1));
        din      = 8'($urandom_range(0, 255));
        tick();
      end
      in_valid = 1'b1;
      in_sof   = (j == 0);
      din      = cw[j];
      tick();
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    if (n == 255) begin
      exp_q.push_back(model());
      due_q.push_back(cyc);
    end
  endtask

  task automatic fill(input int kind);
    for (int j = 0; j < 255; j++) begin
      case (kind)
        0: cw[j] = 8'h00;
        1: cw[j] = (j == 254) ? 8'h01 : 8'h00;
        2: cw[j] = (j == 0) ? 8'h01 : 8'h00;
        default: cw[j] = 8'($urandom_range(0, 255));
      endcase
    end
  endtask

  task automatic do_reset();
    hold_en  = 1'b0;
    clrn     = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    tick();
    tick();
    clrn = 1'b1;
    last = '0;
    check("reset_outputs", obs, '0);
    check("reset_syn_valid", {128'd0, syn_valid}, '0);
    check("reset_busy", {128'd0, busy}, '0);
    hold_en = 1'b1;
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (clrn === 1'b1) begin
      if (syn_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_syn_valid got=%h exp=none", obs);
        end else begin
          logic [128:0] e;
          int d;
          e = exp_q.pop_front();
          d = due_q.pop_front();
          last = e;
          if (obs !== e) begin
            errors++;
            $display("FAIL syn_set got=%h exp=%h", obs, e);
          end
          checks++;
          if (cyc != d) begin
            errors++;
            $display("FAIL latency got_cycle=%0d exp_cycle=%0d", cyc, d);
          end
        end
      end else if (hold_en) begin
        checks++;
        if (obs !== last) begin
          errors++;
          $display("FAIL hold got=%h exp=%h", obs, last);
        end
      end
    end
  end

  initial begin
    logic [7:0] x;
    x = 8'h01;
    for (int k = 0; k < 255; k++) begin
      exp_t[k] = x;
      x = fmul(x, 8'h02);
    end
    last     = '0;
    din      = 8'h00;
    do_reset();

    // symbols without sof in IDLE are ignored
    repeat (5) begin
      in_valid = 1'b1; in_sof = 1'b0; din = 8'($urandom_range(1, 255));
      tick();
    end
    in_valid = 1'b0;
    check("idle_ignore_busy", {128'd0, busy}, '0);

    fill(0); send_cw(255, 0);
    check("done_busy", {128'd0, busy}, '0);
    fill(1); send_cw(255, 0);
    fill(2); send_cw(255, 0);
    tick();
    check("deg254_s1", {121'd0, syndrome1}, {121'd0, 8'h8E});
    check("deg254_s2", {121'd0, syndrome2}, {121'd0, 8'h47});
    fill(1); send_cw(255, 20);
    tick();

    // back-to-back, no gap
    fill(0); send_cw(255, 0);
    fill(1); send_cw(255, 0);
    tick();

    for (int r = 0; r < 3; r++) begin
      fill(3); send_cw(255, 5);
      repeat ($urandom_range(0, 3)) tick();
    end

    // restart after 100 symbols
    fill(3); send_cw(100, 0);
    check("partial_busy", {128'd0, busy}, {128'd0, 1'b1});
    fill(1); send_cw(255, 0);
    tick();

    // reset mid-codeword discards it
    fill(3); send_cw(50, 2);
    do_reset();
    repeat (30) begin
      in_valid = 1'b1; in_sof = 1'b0; din = 8'($urandom_range(0, 255));
      tick();
    end
    in_valid = 1'b0;
    fill(1); send_cw(255, 3);

    repeat (10) tick();
    check("drain", {97'd0, 32'(exp_q.size())}, '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
